imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Single-port instruction BRAM arbiter between the fetch unit and the program loader.
// Optional anti-starvation for fetch is enabled by defining IMEM_ARB_ANTISTARVE_EN.
module imem_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOAD
    } owner_t;

    owner_t            owner_q, owner_d;
    logic              force_fetch;
    logic [ADDR_W-1:0] fetch_idx;

    // PC byte-offset and bits above the BRAM depth are dropped (address wraps).
    assign fetch_idx = f_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0]};

`ifdef IMEM_ARB_ANTISTARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_fetch = (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = '0;
        if (f_req && !f_gnt) begin
            starve_d = force_fetch ? starve_q : starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT != 0);
    assign force_fetch       = 1'b0;
`endif

    always_comb begin
        l_gnt     = !reset && l_req && !(f_req && force_fetch);
        f_gnt     = !reset && f_req && !l_gnt;
        mem_en    = f_gnt || l_gnt;
        mem_we    = l_gnt && l_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else if (f_gnt) begin
            mem_addr  = fetch_idx;
        end
    end

    // A flushed fetch read is never recorded as owned, so its response is killed.
    always_comb begin
        owner_d = OWN_NONE;
        if (l_gnt && !l_we) begin
            owner_d = OWN_LOAD;
        end else if (f_gnt && !f_flush) begin
            owner_d = OWN_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign f_rvalid = (owner_q == OWN_FETCH);
    assign l_rvalid = (owner_q == OWN_LOAD);
    assign f_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural 1-cycle BRAM.
// Expectations follow IMEM_ARB_ANTISTARVE_EN if defined for the build.
module tb_imem_arbiter;

    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_req, f_flush;
    logic [31:0]       f_addr;
    logic              f_gnt, f_rvalid;
    logic [31:0]       f_rdata;
    logic              l_req, l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt, l_rvalid;
    logic [31:0]       l_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] bram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr];
        end
    end

    imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic test_reset();
        reset = 1'b1; f_req = 1'b1; l_req = 1'b1; l_we = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we});
        end
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: f_rvalid=%b l_rvalid=%b mem_en=%b expected 0 0 0",
                     f_rvalid, l_rvalid, mem_en);
        end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h0000_0013;
        exp_data[1] = 32'h0010_0093;
        exp_data[2] = 32'h0020_0113;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (f_rvalid !== 1'b1 || f_rdata !== exp_data[i-1]) begin
                    errors++;
                    $display("FAIL fetch_stream_data[%0d]: rvalid=%b data=%h expected 1 %h",
                             i - 1, f_rvalid, f_rdata, exp_data[i-1]);
                end
            end
            f_req  = (i < 3);
            f_addr = 32'(i * 4);
            #1;
            if (i < 3) begin
                checks++;
                if (f_gnt !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_stream_gnt[%0d]: gnt=%b addr=%0d we=%b expected 1 %0d 0",
                             i, f_gnt, mem_addr, mem_we, i);
                end
            end
        end
    endtask

    task automatic test_loader_write_then_fetch();
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b1; l_addr = 9'd64; l_wdata = 32'h0640_0693;
        #1;
        checks++;
        if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 9'd64
            || mem_wdata !== 32'h0640_0693) begin
            errors++;
            $display("FAIL loader_write_gnt: l_gnt=%b f_gnt=%b we=%b addr=%0d wdata=%h expected 1 0 1 64 06400693",
                     l_gnt, f_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (l_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL loader_write_no_rvalid: l_rvalid=%b f_rvalid=%b expected 0 0",
                     l_rvalid, f_rvalid);
        end
        l_req = 1'b0; l_we = 1'b0;
        f_req = 1'b1; f_addr = 32'h100;
        #1;
        checks++;
        if (f_gnt !== 1'b1 || mem_addr !== 9'd64) begin
            errors++;
            $display("FAIL fetch_after_write_gnt: gnt=%b addr=%0d expected 1 64", f_gnt, mem_addr);
        end
        @(negedge clk);
        f_req = 1'b0;
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h0640_0693) begin
            errors++;
            $display("FAIL fetch_after_write_data: rvalid=%b data=%h expected 1 06400693",
                     f_rvalid, f_rdata);
        end
    endtask

    task automatic test_loader_read();
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'd2;
        @(negedge clk);
        l_req = 1'b0;
        checks++;
        if (l_rvalid !== 1'b1 || f_rvalid !== 1'b0 || l_rdata !== 32'h0020_0113) begin
            errors++;
            $display("FAIL loader_read: l_rvalid=%b f_rvalid=%b data=%h expected 1 0 00200113",
                     l_rvalid, f_rvalid, l_rdata);
        end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        f_req = 1'b1; f_addr = 32'hFFFF_F807;
        #1;
        checks++;
        if (f_gnt !== 1'b1 || mem_addr !== 9'd1) begin
            errors++;
            $display("FAIL addr_wrap_idx: gnt=%b addr=%0d expected 1 1", f_gnt, mem_addr);
        end
        @(negedge clk);
        f_req = 1'b0;
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL addr_wrap_data: rvalid=%b data=%h expected 1 00100093", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic exp_f;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            l_req = 1'b1; l_we = 1'b0; l_addr = 9'd0;
            f_req = 1'b1; f_addr = 32'h0;
            #1;
`ifdef IMEM_ARB_ANTISTARVE_EN
            exp_f = (c == 5);
`else
            exp_f = 1'b0;
`endif
            checks++;
            if (f_gnt !== exp_f || l_gnt !== !exp_f) begin
                errors++;
                $display("FAIL arb_cycle%0d: f_gnt=%b l_gnt=%b expected %b %b",
                         c, f_gnt, l_gnt, exp_f, !exp_f);
            end
        end
        @(negedge clk);
        l_req = 1'b0; f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        f_req = 1'b1; f_addr = 32'h30; f_flush = 1'b1;
        #1;
        checks++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_gnt: f_gnt=%b expected 1", f_gnt);
        end
        @(negedge clk);
        f_flush = 1'b0; f_addr = 32'h100;
        #1;
        checks++;
        if (f_rvalid !== 1'b0 || f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_kill: f_rvalid=%b f_gnt=%b expected 0 1", f_rvalid, f_gnt);
        end
        @(negedge clk);
        f_req = 1'b0;
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h0640_0693) begin
            errors++;
            $display("FAIL flush_next_fetch: rvalid=%b data=%h expected 1 06400693",
                     f_rvalid, f_rdata);
        end
        // flush alongside a loader read must not disturb it
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'd0; f_flush = 1'b1;
        #1;
        checks++;
        if (l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_loader_gnt: l_gnt=%b expected 1", l_gnt);
        end
        @(negedge clk);
        l_req = 1'b0; f_flush = 1'b0;
        checks++;
        if (l_rvalid !== 1'b1 || l_rdata !== 32'h0000_0013) begin
            errors++;
            $display("FAIL flush_loader_resp: l_rvalid=%b data=%h expected 1 00000013",
                     l_rvalid, l_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'd1;
        #1;
        checks++;
        if (l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_gnt: l_gnt=%b expected 1", l_gnt);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (l_gnt !== 1'b0 || f_gnt !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_grants: l_gnt=%b f_gnt=%b mem_en=%b expected 0 0 0",
                     l_gnt, f_gnt, mem_en);
        end
        @(negedge clk);
        checks++;
        if (l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard: l_rvalid=%b expected 0", l_rvalid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (l_rvalid !== 1'b0 || l_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_resume: l_rvalid=%b l_gnt=%b expected 0 1", l_rvalid, l_gnt);
        end
        @(negedge clk);
        l_req = 1'b0;
        checks++;
        if (l_rvalid !== 1'b1 || l_rdata !== 32'h0010_0093) begin
            errors++;
            $display("FAIL midrst_after_read: l_rvalid=%b data=%h expected 1 00100093",
                     l_rvalid, l_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) bram[i] = 32'h0;
        bram[0] = 32'h0000_0013;
        bram[1] = 32'h0010_0093;
        bram[2] = 32'h0020_0113;
        mem_rdata = 32'h0;
        reset = 1'b1;
        f_req = 1'b0; f_addr = 32'h0; f_flush = 1'b0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = 32'h0;

        test_reset();
        test_fetch_stream();
        test_loader_write_then_fetch();
        test_loader_read();
        test_addr_wrap();
        test_arbitration();
        test_flush();
        test_reset_mid_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
